regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
//  Shares the single register-file write port between the ALU writeback path and the memory (load) writeback path.
//  Keeps a 32-entry pending-destination scoreboard so decode can detect RAW hazards on its two read registers.
//  Sits between the EX/MEM writeback sources and the register file write port (writeEnable/writeReg/writeData).
// PARAMETERS
//  DATA_W      32  width of write data
//  ADDR_W      5   register index width (2**ADDR_W entries)
//  STARVE_MAX  4   consecutive ALU denials before the ALU is forced a grant (>=1)
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  alu_valid    in   1       ALU writeback request
//  alu_ready    out  1       ALU request granted this cycle (combinational)
//  alu_reg      in   ADDR_W  ALU destination register
//  alu_data     in   DATA_W  ALU result
//  mem_valid    in   1       load writeback request
//  mem_ready    out  1       load request granted this cycle (combinational)
//  mem_reg      in   ADDR_W  load destination register
//  mem_data     in   DATA_W  load data
//  rsv_valid    in   1       decode issues an instruction that writes rsv_reg
//  rsv_reg      in   ADDR_W  destination being reserved
//  flush        in   1       pipeline flush: drop all reservations
//  chk_reg1     in   ADDR_W  decode source register 1
//  chk_reg2     in   ADDR_W  decode source register 2
//  hazard1      out  1       chk_reg1 has a pending write (combinational)
//  hazard2      out  1       chk_reg2 has a pending write (combinational)
//  rf_we        out  1       register-file write enable (registered)
//  rf_waddr     out  ADDR_W  register-file write index (registered)
//  rf_wdata     out  DATA_W  register-file write data (registered)
//  pending      out  2**ADDR_W  scoreboard bit vector (registered)
// BEHAVIOUR
//  Reset (rst_n=0, async): rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, starve_cnt=0. The ready and hazard outputs follow from this state.
//  Arbitration: handshake = valid & ready. Only one grant per cycle.
//   - mem wins by default. The exception is when alu_valid is high and starve_cnt==STARVE_MAX: then alu wins.
//   - Either requester alone is granted immediately. ready never asserts without the matching valid.
//  starve_cnt:
//   - +1 (saturating at STARVE_MAX) when alu_valid and not alu_ready.
//   - Cleared on an ALU grant or when alu_valid=0.
//  Write port: the granted request is registered. rf_we/rf_waddr/rf_wdata are driven the cycle after the handshake (latency 1).
//   - Granted writes to register 0 complete the handshake but produce rf_we=0.
//   - rf_waddr/rf_wdata hold their last value when rf_we=0.
//  Scoreboard:
//   - rsv_valid & rsv_reg!=0 sets pending[rsv_reg] at the clock edge.
//   - rf_we=1 clears pending[rf_waddr] at the end of that cycle. The write is visible in the register file on the next cycle, and hazard drops on the same cycle.
//   - Set and clear of the same register in the same cycle: set wins (new producer).
//   - flush: all pending bits clear at the edge; a same-cycle rsv_valid is dropped. Writebacks already accepted still drive rf_we.
//  Hazards: hazardN = pending[chk_regN] & (chk_regN!=0). They do not include a same-cycle reservation.
//  Requests not granted must be held stable by the source until ready. The block does not buffer them.
//  Reset asserted mid-operation: an in-flight registered write is discarded (rf_we forced to 0 immediately).
// STRUCTURE
//  Package regfile_sched_pkg:
//   - DATA_W/ADDR_W constants.
//   - typedef wb_req_t {valid, reg, data}.
//   - NREGS = 2**ADDR_W.
//  Sub-module regfile_scoreboard holds the pending vector with its set/clear/flush logic and both hazard lookups.
//  The top level holds the arbiter, starve counter and write-port register.
// TESTING
//  1. Reset, then alu_valid=1 alu_reg=5 alu_data=0xA5 -> alu_ready=1 same cycle; next cycle rf_we=1 rf_waddr=5 rf_wdata=0xA5.
//  2. alu and mem both valid and held for 6 cycles, STARVE_MAX=4:
//     mem granted on cycles 0-3 and 5, alu granted on cycle 4; starve_cnt returns to 0 after the cycle-4 grant.
//  3. rsv reg 7, then chk_reg1=7 -> hazard1=1. mem write to r7 granted on cycle N -> rf_we on N+1, hazard1=1 through N+1 and 0 on N+2.
//  4. rsv reg 3 in the same cycle that rf_we clears r3 -> pending[3] stays 1; rsv reg 0 -> pending unchanged, hazard for chk 0 is always 0.
//  5. Write request to reg 0 with data 0xFF -> ready=1, rf_we stays 0. Then set pending r1,r2,r9 and pulse flush alongside rsv r4 -> pending==0.
//  6. Assert rst_n=0 mid-clock the cycle after a grant -> rf_we=0 and pending=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_sched_pkg.sv
// regfile_sched_pkg: shared widths and writeback request type for the register-file write scheduler
// Exports DATA_W/ADDR_W defaults, NREGS (scoreboard size) and wb_req_t {valid, wreg, data}.
package regfile_sched_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS = 2 ** ADDR_W;
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] wreg;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-destination vector with reserve/retire/flush and two hazard lookups
// Ports: clk, rst_n (async active-low); rsv_valid/rsv_reg reserve a destination;
// flush drops all reservations; clr_en/clr_reg retire the register being written;
// chk_reg1/chk_reg2 -> hazard1/hazard2; pending is the registered scoreboard.
module regfile_scoreboard #(
    parameter int ADDR_W = regfile_sched_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rsv_valid,
    input  logic [ADDR_W-1:0]    rsv_reg,
    input  logic                 flush,
    input  logic                 clr_en,
    input  logic [ADDR_W-1:0]    clr_reg,
    input  logic [ADDR_W-1:0]    chk_reg1,
    input  logic [ADDR_W-1:0]    chk_reg2,
    output logic                 hazard1,
    output logic                 hazard2,
    output logic [2**ADDR_W-1:0] pending
);
    logic [2**ADDR_W-1:0] set_m, clr_m;
    always_comb begin
        set_m = '0;
        clr_m = '0;
        set_m[rsv_reg] = rsv_valid & (rsv_reg != '0);
        clr_m[clr_reg] = clr_en;
    end
    // set is applied after clear so a new producer wins over a retiring one
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pending <= '0;
        else pending <= flush ? '0 : (pending & ~clr_m) | set_m;
    assign hazard1 = pending[chk_reg1] & (chk_reg1 != '0);
    assign hazard2 = pending[chk_reg2] & (chk_reg2 != '0);
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: arbitrates ALU and load writebacks onto the single register-file write port
// Ports: clk, rst_n (async active-low); alu_valid/alu_reg/alu_data -> alu_ready;
// mem_valid/mem_reg/mem_data -> mem_ready; rsv_valid/rsv_reg/flush feed the scoreboard;
// chk_reg1/chk_reg2 -> hazard1/hazard2; rf_we/rf_waddr/rf_wdata registered write port; pending scoreboard.
module regfile_wb_scheduler #(
    parameter int DATA_W     = regfile_sched_pkg::DATA_W,
    parameter int ADDR_W     = regfile_sched_pkg::ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_reg,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_reg,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic                 rsv_valid,
    input  logic [ADDR_W-1:0]    rsv_reg,
    input  logic                 flush,
    input  logic [ADDR_W-1:0]    chk_reg1,
    input  logic [ADDR_W-1:0]    chk_reg2,
    output logic                 hazard1,
    output logic                 hazard2,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic [2**ADDR_W-1:0] pending
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
    logic [CW-1:0] starve_cnt;
    logic [ADDR_W-1:0] g_reg;
    logic [DATA_W-1:0] g_data;
    logic hs, wr;
    // loads win unless the ALU has been denied STARVE_MAX times in a row
    assign alu_ready = alu_valid & (~mem_valid | (starve_cnt == SMAX));
    assign mem_ready = mem_valid & ~alu_ready;
    assign hs = alu_ready | mem_ready;
    assign g_reg = alu_ready ? alu_reg : mem_reg;
    assign g_data = alu_ready ? alu_data : mem_data;
    // r0 writes are accepted but never reach the register file
    assign wr = hs & (g_reg != '0);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            starve_cnt <= '0;
            rf_we <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            starve_cnt <= (alu_valid & ~alu_ready) ? ((starve_cnt == SMAX) ? SMAX : starve_cnt + 1'b1) : '0;
            rf_we <= wr;
            if (wr) begin
                rf_waddr <= g_reg;
                rf_wdata <= g_data;
            end
        end
    regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk(clk), .rst_n(rst_n),
        .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .flush(flush),
        .clr_en(rf_we), .clr_reg(rf_waddr),
        .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
        .hazard1(hazard1), .hazard2(hazard2), .pending(pending)
    );
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed scenarios plus a randomized run against a behavioural model
module tb_regfile_wb_scheduler;
    import regfile_sched_pkg::*;
    localparam int SM = 4;
    logic clk, rst_n;
    logic alu_valid, alu_ready, mem_valid, mem_ready, rsv_valid, flush;
    logic [4:0] alu_reg, mem_reg, rsv_reg, chk_reg1, chk_reg2, rf_waddr;
    logic [31:0] alu_data, mem_data, rf_wdata, pending;
    logic hazard1, hazard2, rf_we;
    int total = 0, bad = 0;

    regfile_wb_scheduler #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .flush(flush),
        .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .hazard1(hazard1), .hazard2(hazard2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic idle();
        alu_valid = 0; alu_reg = 0; alu_data = 0;
        mem_valid = 0; mem_reg = 0; mem_data = 0;
        rsv_valid = 0; rsv_reg = 0; flush = 0;
        chk_reg1 = 0; chk_reg2 = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #2;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset.rf_we got=%0h want=0", rf_we); end
        total++; if (rf_waddr !== 5'd0) begin bad++; $display("FAIL reset.rf_waddr got=%0h want=0", rf_waddr); end
        total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL reset.rf_wdata got=%0h want=0", rf_wdata); end
        total++; if (pending !== 32'd0) begin bad++; $display("FAIL reset.pending got=%0h want=0", pending); end
        total++; if ({alu_ready, mem_ready, hazard1, hazard2} !== 4'b0) begin bad++; $display("FAIL reset.comb got=%b want=0000", {alu_ready, mem_ready, hazard1, hazard2}); end
        @(negedge clk);
        rst_n = 1;
        next();
    endtask

    task automatic test_alu_single();
        alu_valid = 1; alu_reg = 5; alu_data = 32'hA5;
        #1;
        total++; if ({alu_ready, mem_ready} !== 2'b10) begin bad++; $display("FAIL alu_single.ready got=%b want=10", {alu_ready, mem_ready}); end
        next();
        idle();
        total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hA5}) begin bad++; $display("FAIL alu_single.write got=%0h/%0h/%0h want=1/5/a5", rf_we, rf_waddr, rf_wdata); end
        next();
        total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'hA5}) begin bad++; $display("FAIL alu_single.hold got=%0h/%0h/%0h want=0/5/a5", rf_we, rf_waddr, rf_wdata); end
    endtask

    task automatic test_starve();
        alu_valid = 1; alu_reg = 10; alu_data = 32'h10;
        mem_valid = 1; mem_reg = 11; mem_data = 32'h11;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if ({alu_ready, mem_ready} !== ((i == 4) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL starve.grant cyc=%0d got=%b want=%b", i, {alu_ready, mem_ready}, (i == 4) ? 2'b10 : 2'b01); end
            next();
            total++; if (rf_waddr !== ((i == 4) ? 5'd10 : 5'd11)) begin bad++; $display("FAIL starve.waddr cyc=%0d got=%0d want=%0d", i, rf_waddr, (i == 4) ? 10 : 11); end
        end
        idle();
        next();
    endtask

    task automatic test_hazard();
        rsv_valid = 1; rsv_reg = 7; chk_reg1 = 7;
        #1;
        total++; if (hazard1 !== 1'b0) begin bad++; $display("FAIL hazard.same_cycle got=%0h want=0", hazard1); end
        next();
        rsv_valid = 0;
        mem_valid = 1; mem_reg = 7; mem_data = 32'h77;
        #1;
        total++; if ({hazard1, mem_ready} !== 2'b11) begin bad++; $display("FAIL hazard.cycN got=%b want=11", {hazard1, mem_ready}); end
        next();
        mem_valid = 0;
        #1;
        total++; if ({hazard1, rf_we, rf_waddr} !== {2'b11, 5'd7}) begin bad++; $display("FAIL hazard.cycN1 got=%0h/%0h/%0h want=1/1/7", hazard1, rf_we, rf_waddr); end
        next();
        total++; if ({hazard1, rf_we} !== 2'b00) begin bad++; $display("FAIL hazard.cycN2 got=%b want=00", {hazard1, rf_we}); end
        idle();
    endtask

    task automatic test_set_wins();
        logic [31:0] snap;
        rsv_valid = 1; rsv_reg = 3;
        next();
        rsv_valid = 0;
        mem_valid = 1; mem_reg = 3; mem_data = 32'h33;
        next();
        mem_valid = 0;
        rsv_valid = 1; rsv_reg = 3; chk_reg2 = 3;
        next();
        rsv_valid = 0;
        total++; if ({pending[3], hazard2} !== 2'b11) begin bad++; $display("FAIL set_wins.r3 got=%b want=11", {pending[3], hazard2}); end
        snap = pending;
        rsv_valid = 1; rsv_reg = 0; chk_reg1 = 0;
        #1;
        total++; if (hazard1 !== 1'b0) begin bad++; $display("FAIL set_wins.chk0 got=%0h want=0", hazard1); end
        next();
        rsv_valid = 0;
        total++; if (pending !== snap) begin bad++; $display("FAIL set_wins.rsv0 got=%0h want=%0h", pending, snap); end
        idle();
    endtask

    task automatic test_reg0_flush();
        alu_valid = 1; alu_reg = 0; alu_data = 32'hFF;
        #1;
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL reg0.ready got=%0h want=1", alu_ready); end
        next();
        alu_valid = 0;
        total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd3, 32'h33}) begin bad++; $display("FAIL reg0.write got=%0h/%0h/%0h want=0/3/33", rf_we, rf_waddr, rf_wdata); end
        rsv_valid = 1; rsv_reg = 1; next();
        rsv_reg = 2; next();
        rsv_reg = 9;
        mem_valid = 1; mem_reg = 5; mem_data = 32'h55;
        next();
        rsv_valid = 0; mem_valid = 0;
        total++; if (pending !== 32'h0000_020E) begin bad++; $display("FAIL flush.before got=%0h want=20e", pending); end
        flush = 1; rsv_valid = 1; rsv_reg = 4; chk_reg1 = 4;
        #1;
        total++; if ({rf_we, rf_waddr} !== {1'b1, 5'd5}) begin bad++; $display("FAIL flush.inflight got=%0h/%0h want=1/5", rf_we, rf_waddr); end
        next();
        idle();
        chk_reg1 = 4;
        total++; if ({pending, hazard1} !== 33'd0) begin bad++; $display("FAIL flush.after got=%0h/%0h want=0/0", pending, hazard1); end
        idle();
    endtask

    task automatic test_async_reset();
        alu_valid = 1; alu_reg = 6; alu_data = 32'h66;
        rsv_valid = 1; rsv_reg = 8;
        next();
        idle();
        total++; if ({rf_we, pending[8]} !== 2'b11) begin bad++; $display("FAIL areset.pre got=%b want=11", {rf_we, pending[8]}); end
        #1;
        rst_n = 0;
        #1;
        total++; if ({rf_we, pending, rf_waddr, rf_wdata} !== '0) begin bad++; $display("FAIL areset.now got=%0h/%0h/%0h/%0h want=0", rf_we, pending, rf_waddr, rf_wdata); end
        @(negedge clk);
        rst_n = 1;
        next();
    endtask

    task automatic test_random();
        wb_req_t a, m;
        bit mp[32];
        int deny, rf_cnt;
        bit ew, ag, mg;
        logic [4:0] ea;
        logic [31:0] ed, ep;
        a = '0; m = '0; deny = 0; ew = 0; ea = 0; ed = 0; rf_cnt = 0;
        foreach (mp[i]) mp[i] = 0;
        for (int c = 0; c < 400; c++) begin
            if (!a.valid) a = '{valid: 1'($urandom_range(0, 1)), wreg: 5'($urandom), data: $urandom};
            if (!m.valid) m = '{valid: 1'($urandom_range(0, 2) != 0), wreg: 5'($urandom), data: $urandom};
            alu_valid = a.valid; alu_reg = a.wreg; alu_data = a.data;
            mem_valid = m.valid; mem_reg = m.wreg; mem_data = m.data;
            rsv_valid = 1'($urandom_range(0, 1)); rsv_reg = 5'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            chk_reg1 = 5'($urandom); chk_reg2 = (c % 3 == 0) ? 5'd0 : 5'($urandom);
            #3;
            ag = a.valid && (!m.valid || deny == SM);
            mg = m.valid && !ag;
            ep = '0;
            foreach (mp[i]) ep[i] = mp[i];
            total++; if ({alu_ready, mem_ready} !== {ag, mg}) begin bad++; $display("FAIL rand.grant cyc=%0d got=%b want=%b%b", c, {alu_ready, mem_ready}, ag, mg); end
            total++; if ({hazard1, hazard2} !== {mp[chk_reg1] && chk_reg1 != 0, mp[chk_reg2] && chk_reg2 != 0}) begin bad++; $display("FAIL rand.hazard cyc=%0d got=%b", c, {hazard1, hazard2}); end
            total++; if ({rf_we, rf_waddr, rf_wdata} !== {ew, ea, ed}) begin bad++; $display("FAIL rand.write cyc=%0d got=%0h/%0h/%0h want=%0h/%0h/%0h", c, rf_we, rf_waddr, rf_wdata, ew, ea, ed); end
            total++; if (pending !== ep) begin bad++; $display("FAIL rand.pending cyc=%0d got=%0h want=%0h", c, pending, ep); end
            if (flush) foreach (mp[i]) mp[i] = 0;
            else begin
                if (ew) mp[ea] = 0;
                if (rsv_valid && rsv_reg != 0) mp[rsv_reg] = 1;
            end
            deny = (a.valid && !ag) ? ((deny < SM) ? deny + 1 : SM) : 0;
            ew = 0;
            if (ag && a.wreg != 0) begin ew = 1; ea = a.wreg; ed = a.data; end
            if (mg && m.wreg != 0) begin ew = 1; ea = m.wreg; ed = m.data; end
            rf_cnt += int'(ew);
            if (ag) a.valid = 0;
            if (mg) m.valid = 0;
            next();
        end
        total++; if (rf_cnt < 50) begin bad++; $display("FAIL rand.activity got=%0d want>=50", rf_cnt); end
        idle();
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_starve();
        test_hazard();
        test_set_wins();
        test_reg0_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
